// File: rtl/bnn_frame_io_if.sv
// Purpose: sample-in / result-out handshake bundle for bnn_frame_io.
// Ports:   s_* carries binarizable samples into the block (valid/ready, s_last ends a frame);
//          m_* carries the captured network result out (valid/ready).
// Modports: master = host side driving samples and consuming results; slave = bnn_frame_io.
interface bnn_frame_io_if #(
  parameter int PIX_W = 8,
  parameter int N_OUT = 10
);
  logic             s_valid;
  logic [PIX_W-1:0] s_data;
  logic             s_last;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready;
  logic [N_OUT-1:0] m_result;
  logic [3:0]       m_class;
  logic             m_hit;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_result, m_class, m_hit
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_result, m_class, m_hit
  );
endinterface

// File: rtl/bnn_frame_io.sv
// Purpose: binarize a stream of samples into one N_IN-bit frame for the combinational
//          network, hold it for SETTLE cycles, then capture and decode the network output.
// Latency: last accepted sample to m_valid is SETTLE+1 edges (the beat edge included).
// Backpressure: s_ready drops from frame completion until the result handshake; one frame in flight.
// Ports:   clk/rst (sync, active-high); bus (slave modport: s_* samples in, m_* result out);
//          net_in (frame to network), net_out (network answer), frame_err (1-cycle error pulse).
module bnn_frame_io #(
  parameter int N_IN   = 75,
  parameter int N_OUT  = 10,
  parameter int PIX_W  = 8,
  parameter int THRESH = 128,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  bnn_frame_io_if.slave    bus,
  output logic [N_IN-1:0]  net_in,
  input  logic [N_OUT-1:0] net_out,
  output logic             frame_err
);

  localparam int            CW          = $clog2(N_IN);
  localparam logic [CW-1:0] LAST_IDX    = CW'(N_IN - 1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_SETTLE,
    ST_RESULT
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       settle_q;
  logic [N_IN-1:0]  shadow_q;
  logic [N_IN-1:0]  net_in_q;
  logic             s_ready_q;
  logic             m_valid_q;
  logic [N_OUT-1:0] m_result_q;
  logic [3:0]       m_class_q;
  logic             m_hit_q;
  logic             frame_err_q;

  logic             beat;
  logic             sample_bit;
  logic [N_IN-1:0]  shadow_full;
  logic [3:0]       class_nxt;

  assign beat       = bus.s_valid & s_ready_q;
  assign sample_bit = (bus.s_data >= PIX_W'(THRESH));

  // Shadow with the current beat's bit merged in, so the frame can be
  // published to net_in on the same edge that accepts its last sample.
  always_comb begin
    shadow_full        = shadow_q;
    shadow_full[cnt_q] = sample_bit;
  end

  // Lowest set bit wins: scan from the top so lower indices overwrite.
  always_comb begin
    class_nxt = 4'hF;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (net_out[i]) class_nxt = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      settle_q    <= '0;
      shadow_q    <= '0;
      net_in_q    <= '0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_result_q  <= '0;
      m_class_q   <= 4'hF;
      m_hit_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (beat) begin
            if (cnt_q == LAST_IDX) begin
              cnt_q <= '0;
              if (bus.s_last) begin
                net_in_q  <= shadow_full;
                settle_q  <= '0;
                s_ready_q <= 1'b0;
                state_q   <= ST_SETTLE;
              end else begin
                // Frame overran: drop it and swallow samples up to the next s_last.
                frame_err_q <= 1'b1;
                state_q     <= ST_DRAIN;
              end
            end else if (bus.s_last) begin
              // Short frame. Stale shadow bits are harmless: every index is
              // rewritten before the next frame can complete.
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              shadow_q <= shadow_full;
              cnt_q    <= cnt_q + CW'(1);
            end
          end
        end

        ST_DRAIN: begin
          if (beat && bus.s_last) begin
            cnt_q   <= '0;
            state_q <= ST_LOAD;
          end
        end

        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            m_result_q <= net_out;
            m_hit_q    <= |net_out;
            m_class_q  <= class_nxt;
            m_valid_q  <= 1'b1;
            state_q    <= ST_RESULT;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end

        ST_RESULT: begin
          // m_result/m_class/m_hit intentionally keep their values after the handshake.
          if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= ST_LOAD;
          end
        end

        default: begin
          state_q   <= ST_LOAD;
          cnt_q     <= '0;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign net_in       = net_in_q;
  assign frame_err    = frame_err_q;
  assign bus.s_ready  = s_ready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_result = m_result_q;
  assign bus.m_class  = m_class_q;
  assign bus.m_hit    = m_hit_q;

endmodule

// File: tb/tb_bnn_frame_io.sv
module tb_bnn_frame_io;
  localparam int N_IN   = 75;
  localparam int N_OUT  = 10;
  localparam int PIX_W  = 8;
  localparam int THRESH = 128;
  localparam int SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_IN-1:0]  net_in;
  logic [N_OUT-1:0] net_out;
  logic             frame_err;

  bnn_frame_io_if #(.PIX_W(PIX_W), .N_OUT(N_OUT)) bus ();

  bnn_frame_io #(
    .N_IN(N_IN), .N_OUT(N_OUT), .PIX_W(PIX_W), .THRESH(THRESH), .SETTLE(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .net_in(net_in),
    .net_out(net_out),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N_OUT-1:0] res;
    logic [N_IN-1:0]  vec;
    int               beat_cyc;
  } exp_t;

  exp_t            exp_q[$];
  logic [7:0]      frame[$];
  int              exp_err  = 0;
  int              seen_err = 0;
  logic [N_IN-1:0] last_vec = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference rules: class = index of lowest set bit (F if none); frame bit i = sample i >= THRESH.
  function automatic logic [3:0] ref_class(input logic [N_OUT-1:0] r);
    for (int i = 0; i < N_OUT; i++) if (r[i]) return 4'(i);
    return 4'hF;
  endfunction

  function automatic logic [N_IN-1:0] ref_vec();
    logic [N_IN-1:0] v = '0;
    for (int i = 0; i < N_IN; i++) v[i] = (int'(frame[i]) >= THRESH);
    return v;
  endfunction

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    int n = 0;
    logic acc = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!acc && n < 200) begin
      @(negedge clk); acc = bus.s_ready;
      @(posedge clk); #1; n++;
    end
    check("beat_accept", acc, 1'b1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    check({tag, "_net_in"},    net_in,       '0);
    check({tag, "_m_valid"},   bus.m_valid,  1'b0);
    check({tag, "_m_result"},  bus.m_result, '0);
    check({tag, "_m_class"},   bus.m_class,  4'hF);
    check({tag, "_m_hit"},     bus.m_hit,    1'b0);
    check({tag, "_frame_err"}, frame_err,    1'b0);
    check({tag, "_s_ready"},   bus.s_ready,  1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    last_vec = '0;
    check_reset(tag);
  endtask

  // Sends the samples in 'frame' with s_last on the final one and records what must follow.
  task automatic send_frame(input logic [N_OUT-1:0] nout, input int gap_pct);
    exp_t e;
    for (int i = 0; i < frame.size(); i++) begin
      if (i == frame.size() - 1) net_out = nout;
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
      beat(frame[i], i == frame.size() - 1);
    end
    if (frame.size() == N_IN) begin
      e.res      = nout;
      e.vec      = ref_vec();
      e.beat_cyc = cyc;
      last_vec   = e.vec;
      exp_q.push_back(e);
    end else begin
      exp_err++;
    end
  endtask

  task automatic rand_frame(input int len);
    frame.delete();
    for (int i = 0; i < len; i++) frame.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic get_result(input int hold, input bit busy_in);
    int n = 0;
    bus.m_ready = 1'b0;
    while (!bus.m_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("result_arrives", bus.m_valid, 1'b1);
    if (busy_in) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'($urandom);
      bus.s_last  = 1'($urandom);
    end
    repeat (hold) begin
      if (busy_in) net_out = N_OUT'($urandom);
      @(negedge clk);
      check("s_ready_in_result", bus.s_ready, 1'b0);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("m_valid_after_hs", bus.m_valid, 1'b0);
    check("s_ready_after_hs", bus.s_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on each new result and checks it is held until the handshake.
  initial begin
    logic             mv_prev = 1'b0;
    logic [N_OUT-1:0] held_res = '0;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (frame_err) seen_err++;
      if (bus.m_valid && !mv_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result actual=m_valid required=no result (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          held_res = e.res;
          check("m_result", bus.m_result, e.res);
          check("m_class",  bus.m_class,  ref_class(e.res));
          check("m_hit",    bus.m_hit,    e.res != '0);
          check("net_in",   net_in,       e.vec);
          check("latency",  cyc - e.beat_cyc, SETTLE);
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        check("m_result_stable", bus.m_result, held_res);
        check("m_class_stable",  bus.m_class,  ref_class(held_res));
      end
      mv_prev = bus.m_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    net_out     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset0");

    // All samples above threshold, single output bit 5.
    frame.delete();
    repeat (N_IN) frame.push_back(8'd200);
    send_frame(10'b0000100000, 0);
    check("t1_net_in", net_in, {N_IN{1'b1}});
    get_result(0, 0);

    // Threshold boundary: 127 -> 0, 128 -> 1; empty network output.
    frame.delete();
    for (int i = 0; i < N_IN; i++) frame.push_back((i % 2) ? 8'd128 : 8'd127);
    send_frame('0, 0);
    get_result(2, 0);

    // Short frame (s_last on beat 40), then a clean frame.
    rand_frame(40);
    send_frame('0, 0);
    idle(SETTLE + 4);
    check("t3_no_result", bus.m_valid, 1'b0);
    rand_frame(N_IN);
    send_frame(N_OUT'($urandom), 10);
    get_result(1, 0);

    // Overlong frame: error at beat 75, drain three more, net_in untouched.
    rand_frame(N_IN);
    for (int i = 0; i < N_IN; i++) beat(frame[i], 1'b0);
    exp_err++;
    beat(8'd10, 1'b0);
    beat(8'd250, 1'b0);
    beat(8'd130, 1'b1);
    idle(SETTLE + 3);
    check("t4_net_in_kept", net_in, last_vec);
    check("t4_no_result", bus.m_valid, 1'b0);
    rand_frame(N_IN);
    send_frame(10'b1000000000, 0);
    get_result(0, 0);

    // Long stall in RESULT with input pressure and a moving net_out.
    rand_frame(N_IN);
    send_frame(10'b0000001100, 0);
    get_result(20, 1);

    // Reset mid-frame, then a full frame.
    rand_frame(50);
    for (int i = 0; i < 50; i++) beat(frame[i], 1'b0);
    do_reset("rst_midframe");
    rand_frame(N_IN);
    send_frame(N_OUT'($urandom), 0);
    get_result(0, 0);

    // Reset during SETTLE, then a full frame.
    rand_frame(N_IN);
    send_frame(10'h3FF, 0);
    do_reset("rst_settle");
    rand_frame(N_IN);
    send_frame(10'b0001000000, 0);
    get_result(1, 0);

    // Randomized traffic with occasional short frames.
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 99) < 20) begin
        rand_frame($urandom_range(1, N_IN - 1));
        send_frame('0, 10);
      end
      rand_frame(N_IN);
      send_frame(($urandom_range(0, 3) == 0) ? N_OUT'(0) : N_OUT'($urandom), 20);
      get_result($urandom_range(0, 4), $urandom_range(0, 1) == 1);
    end

    idle(10);
    check("frame_err_count", seen_err, exp_err);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
